// File: rtl/booth_seq_mult_ctrl.sv
// Purpose : iterative radix-4 Booth multiplier sequencer (unsigned WIDTH x WIDTH -> 2*WIDTH).
// Latency : NDIG cycles from accept to out_valid (fewer when BOOTH_EARLY_TERM_EN is defined).
// Backpres: in_ready only in IDLE; the product is held in DONE until out_ready.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (a, b unsigned WIDTH)
//   out_valid/out_ready  product handshake (prod unsigned 2*WIDTH)
//   busy                 high in RUN or DONE
//   sel_neg/zero/one/two Booth digit selects for the shared partial-product generator
//
// Optional feature macro: BOOTH_EARLY_TERM_EN -- stop iterating once every
// remaining Booth digit is zero.
module booth_seq_mult_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy,
    output logic               sel_neg,
    output logic               sel_zero,
    output logic               sel_one,
    output logic               sel_two
);

    localparam int NDIG = WIDTH / 2 + 1;
    localparam int CW   = $clog2(NDIG);
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_sh_q;     // multiplicand pre-shifted by 2*cnt
    logic [WIDTH+2:0] mreg_q;    // multiplier, shifted right 2 per digit
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;

    logic [2:0]      win;
    logic            last_dig;
    logic [PW-1:0]   mag;
    logic [PW-1:0]   pp;

    // The current window always sits in the low three bits because mreg
    // shifts right as digits are consumed; likewise a_sh carries the 4^i weight.
    assign win = mreg_q[2:0];

`ifdef BOOTH_EARLY_TERM_EN
    // Nothing left above the current window means every later digit is zero.
    assign last_dig = (cnt_q == CW'(NDIG - 1)) || (mreg_q[WIDTH+2:3] == '0);
`else
    assign last_dig = (cnt_q == CW'(NDIG - 1));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_RUN;
            ST_RUN:  if (last_dig) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: handshakes and Booth digit decode
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        sel_neg   = 1'b0;
        sel_zero  = 1'b1;
        sel_one   = 1'b0;
        sel_two   = 1'b0;
        if (state_q == ST_RUN) begin
            case (win)
                3'b001, 3'b010: begin sel_zero = 1'b0; sel_one = 1'b1; end
                3'b011:         begin sel_zero = 1'b0; sel_two = 1'b1; end
                3'b100:         begin sel_zero = 1'b0; sel_two = 1'b1; sel_neg = 1'b1; end
                3'b101, 3'b110: begin sel_zero = 1'b0; sel_one = 1'b1; sel_neg = 1'b1; end
                default:        ;
            endcase
        end
    end

    // Shared partial-product generator; negation modulo 2^PW matches the
    // negated unshifted term shifted afterwards.
    always_comb begin
        mag = '0;
        if (sel_two) begin
            mag = {a_sh_q[PW-2:0], 1'b0};
        end else if (sel_one) begin
            mag = a_sh_q;
        end
        pp = sel_neg ? (~mag + PW'(1)) : mag;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q <= '0;
            mreg_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_q <= {{WIDTH{1'b0}}, a};
                        mreg_q <= {2'b00, b, 1'b0};
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                ST_RUN: begin
                    acc_q  <= acc_q + pp;
                    a_sh_q <= {a_sh_q[PW-3:0], 2'b00};
                    mreg_q <= {2'b00, mreg_q[WIDTH+2:2]};
                    cnt_q  <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // acc is untouched outside RUN, so it doubles as the held product.
    assign prod = acc_q;

endmodule

// File: doc/booth_seq_mult_ctrl.md
Name: booth_seq_mult_ctrl

Overview:
Iterative radix-4 Booth multiplier sequencer for the mantissa-multiply datapath. It accepts an unsigned WIDTH x WIDTH operand pair over a valid/ready handshake. Each cycle it scans one Booth window of the multiplier and drives the neg/zero/one/two selects into a single shared partial-product generator. It accumulates the shifted partial products into a 2*WIDTH product, trading latency for area against the fully parallel tree.

Parameters:
WIDTH, 64, operand width in bits; must be even and >= 4
NDIG, WIDTH/2+1, derived localparam: Booth digit count; the extra digit handles the unsigned top bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (IDLE only)
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
prod  output  2*WIDTH  unsigned product a*b
busy  output  1  high in RUN or DONE
sel_neg  output  1  current Booth digit negative
sel_zero  output  1  current Booth digit zero
sel_one  output  1  current digit magnitude 1
sel_two  output  1  current digit magnitude 2

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, prod=0, acc=0, cnt=0, sel_zero=1, other selects 0. Reset in any state, including mid-RUN or DONE with the product unconsumed, aborts the operation; no output is produced.
- The multiplier register is {2'b00, b, 1'b0} (WIDTH+3 bits). Digit i uses window w = mreg[2i+2:2i].
- Encoding:
  - w=000 or 111 -> zero.
  - w=001 or 010 -> +1.
  - w=011 -> +2.
  - w=100 -> -2.
  - w=101 or 110 -> -1.
  - Exactly one of sel_zero/sel_one/sel_two is high. sel_neg=0 whenever sel_zero=1.
- Partial product pp = magnitude*A, zero-extended to 2*WIDTH. It is two's-complement negated (invert + 1) when sel_neg. Each iteration: acc <= acc + (pp << 2i), modulo 2^(2*WIDTH).
- IDLE: in_ready=1. On in_valid&&in_ready: latch a and mreg, acc<=0, cnt<=0, go to RUN.
- RUN: in_ready=0. The selects reflect digit cnt combinationally from registered state. Each cycle: accumulate, cnt<=cnt+1. When cnt==NDIG-1, perform the final accumulate and go to DONE. The selects are driven to zero-digit values outside RUN.
- DONE: out_valid=1, prod=acc, held stable until out_ready. On out_valid&&out_ready, go to IDLE next cycle with out_valid=0. prod keeps the last value in IDLE.
- Latency: accept at edge T gives out_valid high from edge T+NDIG (33 cycles for WIDTH=64).
- Throughput: one operation per NDIG+2 cycles minimum.
- in_valid outside IDLE is ignored, and a/b are not sampled.
- The final acc equals a*b exactly; the unsigned result always fits in 2*WIDTH bits.

Optional Feature:
Macro: BOOTH_EARLY_TERM_EN.
- Defined: in RUN, if mreg bits above window cnt (mreg[WIDTH+2:2cnt+3]) are all zero, the current accumulate is the last one and the block moves to DONE that cycle. Remaining digits are skipped.
- Latency becomes (index of last nonzero digit + 1) cycles, minimum 1.
- Product value is identical to the non-early-termination case.
- Undefined: fixed NDIG iterations always; no early-termination logic synthesized.

Test Plan:
- WIDTH=64, a=3, b=5, out_ready=1 -> prod=15; out_valid rises exactly 33 cycles after accept; in_ready low throughout.
- a=b=0xFFFFFFFFFFFFFFFF -> prod=0xFFFFFFFFFFFFFFFE0000000000000001. The digit sequence must show sel_neg with sel_one at digit 0, sel_zero on the middle digits, and sel_one positive at the top.
- a=0x123456789ABCDEF0, b=0 -> prod=0. sel_zero is high every RUN cycle.
- a=7, b=9, out_ready held low 5 cycles after out_valid -> prod=63 stable and out_valid high for all 6 cycles; a second in_valid asserted during DONE is not accepted until after the transfer plus IDLE.
- rst pulsed at RUN cycle 10 of a=2,b=2 -> next cycle IDLE, out_valid=0, acc=0. A fresh a=4,b=4 then yields 16.
- BOOTH_EARLY_TERM_EN defined, a=11, b=1 -> prod=11 with out_valid 1 cycle after accept; b=0x8000000000000000 -> product correct, latency 33.
